bp_update_ctrl: RTL and testbench
=================================

# bp_update_ctrl

Sequencing controller for the branch predictor's update port. It accepts resolved-branch updates from the execute stage over a valid/ready handshake and buffers them in a small FIFO. It drains them to the predictor one per cycle. It also runs a table-clear sweep after reset and on an explicit flush request, such as fence.i or an address-space change. It sits between the execute/branch-resolution logic and the predictor's `update` modport, and additionally drives a per-entry clear port.

## Interface
- `DEPTH`, 4: update FIFO entries; power of two, ≥2.
- `TABLE_ENTRIES`, 256: predictor entries to sweep; power of two; `IDX_W = $clog2(TABLE_ENTRIES)`.
- `CLK  in  1`: clock.
- `RST  in  1`: asynchronous, active-high reset.
- `upd_valid  in  1`: execute stage presents a resolved branch.
- `upd_ready  out  1`: controller accepts this cycle.
- `upd_pc  in  32`: PC of the resolved branch.
- `upd_target  in  32`: resolved target address.
- `upd_taken  in  1`: actual outcome.
- `upd_predicted  in  1`: outcome the predictor gave.
- `upd_direction  in  1`: backward/forward flag.
- `flush_req  in  1`: single-cycle request to invalidate the whole table.
- `flush_busy  out  1`: a sweep (INIT or FLUSH) is in progress.
- `pred_update  out  1`: maps to `update_predictor`.
- `pred_pc  out  32`: maps to `pc_to_update`.
- `pred_addr  out  32`: maps to `update_addr`.
- `pred_branch_result  out  1`: maps to `branch_result`.
- `pred_prediction  out  1`: maps to `prediction`.
- `pred_direction  out  1`: maps to `direction`.
- `pred_clear  out  1`: clear the predictor entry at `pred_clear_idx`.
- `pred_clear_idx  out  IDX_W`: entry being cleared.
- `mispredict_cnt  out  32`: saturating count of drained updates with `branch_result != prediction`.

## Operation
- FSM states INIT, RUN, FLUSH. RST forces INIT, `idx = 0`, FIFO empty, `mispredict_cnt = 0`.
- **INIT / FLUSH (sweep states)**
  - Outputs: `pred_clear = 1`, `pred_clear_idx = idx`, `flush_busy = 1`, `upd_ready = 0`, `pred_update = 0`.
  - `idx` increments each cycle.
  - At the edge where `idx == TABLE_ENTRIES-1`: go to RUN with `idx = 0`.
  - `flush_req` is ignored in these states.
- **RUN**
  - `pred_clear = 0`, `flush_busy = 0`.
  - `upd_ready = (count < DEPTH)`. A full FIFO with a simultaneous pop still deasserts ready; there is no bypass.
  - Push on `upd_valid && upd_ready`.
  - When the FIFO is non-empty: `pred_update = 1`, `pred_*` show the head entry, and the head pops at the edge. Throughput is 1 update/cycle.
  - On each pop where `taken != predicted`: `mispredict_cnt` increments, holding at 0xFFFF_FFFF.
- **flush_req in RUN**
  - The current cycle's handshake and pop still complete.
  - At the edge: go to FLUSH, empty the FIFO (queued updates are discarded, including one accepted that same cycle), `idx = 0`.
- `pred_*` data outputs are 0 whenever the FIFO is empty or the state is not RUN.
- Pointers wrap modulo DEPTH. Count is `$clog2(DEPTH)+1` bits.

## Timing
- Reset values:
  - Data/control: `upd_ready = 0`, `pred_update = 0`, all `pred_*` data = 0, `mispredict_cnt = 0`.
  - Sweep outputs: `flush_busy = 1`, `pred_clear = 1`, `pred_clear_idx = 0`.
- Sweep length: TABLE_ENTRIES cycles.
  - After RST deasserts, `pred_clear_idx` values 0..TABLE_ENTRIES-1 are presented on consecutive cycles.
  - `upd_ready` first rises TABLE_ENTRIES cycles after the first post-reset edge.
- Latency: an update accepted at edge N appears on `pred_update` in cycle N+1 if the FIFO was empty. It takes `k` more cycles if `k` entries are ahead of it.
- Counter update lands at the same edge as the pop.
- RST asserted mid-sweep or mid-drain: immediate return to reset values, and the sweep restarts from index 0.

## Structure
- Shared package (`branch_predictor_pkg`):
  - `bp_update_t` packed struct: `pc`, `target` (`word_t`), `taken`, `predicted`, `direction`.
  - `bp_ctrl_state_t` enum: INIT, RUN, FLUSH.
- One sub-module, `bp_update_fifo`: parameterised by DEPTH, with ports push/pop/full/empty/count/clear and head data of type `bp_update_t`.
- The top level holds the FSM, the sweep index, the saturating counter and the output muxing.

## Test plan
- **Reset sweep:** deassert RST with TABLE_ENTRIES=8 → `pred_clear` high for 8 cycles, idx 0..7. `upd_ready` rises in cycle 8 and `flush_busy` falls.
- **Single update:** pc=0x100, target=0x80, taken=1, predicted=0 → next cycle `pred_update=1`, `pred_pc=0x100`, `pred_addr=0x80`. `mispredict_cnt` becomes 1.
- **Back-pressure:** hold the predictor output stream and push 6 updates with DEPTH=4 back-to-back → all 6 delivered in order, one per cycle. `upd_ready` never high while count=4.
- **Flush with queued entries:** queue 3 entries, then pulse `flush_req` → the head pops that cycle, the remaining 2 are dropped, and an 8-cycle sweep follows. `flush_req` pulsed mid-sweep has no effect.
- **Counter saturation:** force `mispredict_cnt` to 0xFFFF_FFFE, drain 3 mispredicted updates → value holds at 0xFFFF_FFFF.
- **Mid-operation reset:** assert RST asynchronously while the FIFO is non-empty during RUN → outputs reach reset values without a clock edge, and the sweep restarts at idx 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor update path: the queued update record,
// the update-controller state encoding and the saturating-counter helpers.
package branch_predictor_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t target;
    logic  taken;
    logic  predicted;
    logic  direction;
  } bp_update_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } bp_ctrl_state_t;

  localparam word_t CNT_SAT = 32'hFFFF_FFFF;

  function automatic logic is_mispredict(input bp_update_t u);
    return u.taken != u.predicted;
  endfunction

  // Holds at all-ones instead of wrapping back to zero.
  function automatic word_t sat_inc(input word_t v);
    return (v == CNT_SAT) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Bundle between the execute stage, the update controller and the predictor's
// update/clear ports. The controller takes the slave side.
interface bp_update_ctrl_if #(
  parameter int IDX_W = 8
);
  import branch_predictor_pkg::*;

  logic                 upd_valid;
  logic                 upd_ready;
  word_t                upd_pc;
  word_t                upd_target;
  logic                 upd_taken;
  logic                 upd_predicted;
  logic                 upd_direction;
  logic                 flush_req;
  logic                 flush_busy;
  logic                 pred_update;
  word_t                pred_pc;
  word_t                pred_addr;
  logic                 pred_branch_result;
  logic                 pred_prediction;
  logic                 pred_direction;
  logic                 pred_clear;
  logic [IDX_W-1:0]     pred_clear_idx;
  word_t                mispredict_cnt;

  modport master (
    output upd_valid, upd_pc, upd_target, upd_taken, upd_predicted,
           upd_direction, flush_req,
    input  upd_ready, flush_busy, pred_update, pred_pc, pred_addr,
           pred_branch_result, pred_prediction, pred_direction,
           pred_clear, pred_clear_idx, mispredict_cnt
  );

  modport slave (
    input  upd_valid, upd_pc, upd_target, upd_taken, upd_predicted,
           upd_direction, flush_req,
    output upd_ready, flush_busy, pred_update, pred_pc, pred_addr,
           pred_branch_result, pred_prediction, pred_direction,
           pred_clear, pred_clear_idx, mispredict_cnt
  );

endinterface

// File: rtl/bp_update_fifo.sv
// Small circular buffer of resolved-branch updates. The caller guarantees push
// only when not full; clear wins over a same-cycle push or pop.
module bp_update_fifo
  import branch_predictor_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  bp_update_t       push_data,
  input  logic             pop,
  input  logic             clear,
  output bp_update_t       head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  bp_update_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_pop;

  assign do_pop = pop && (cnt_q != '0);

  // Pointers are exactly PTR_W bits wide, so the power-of-two depth wraps for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!push && do_pop) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/bp_update_ctrl.sv
// Update-port sequencer for the branch predictor: clears the whole table after
// reset or a flush, then drains buffered execute-stage updates one per cycle.
module bp_update_ctrl
  import branch_predictor_pkg::*;
#(
  parameter  int DEPTH         = 4,
  parameter  int TABLE_ENTRIES = 256,
  localparam int IDX_W         = $clog2(TABLE_ENTRIES),
  localparam int CNT_W         = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             rst,
  bp_update_ctrl_if.slave bus
);

  bp_ctrl_state_t   state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  word_t            cnt_q, cnt_d;

  bp_update_t       push_data;
  bp_update_t       head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_clear;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic             upd_ready;
  logic             sweeping;
  logic             head_valid;

  assign push_data = '{pc:        bus.upd_pc,
                       target:    bus.upd_target,
                       taken:     bus.upd_taken,
                       predicted: bus.upd_predicted,
                       direction: bus.upd_direction};

  bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .clear     (fifo_clear),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // A flush still lets this cycle's pop and accept complete; the clear then
  // discards whatever is left, including the update accepted alongside it.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    sweeping   = 1'b0;
    upd_ready  = 1'b0;
    head_valid = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_clear = 1'b0;
    unique case (state_q)
      INIT, FLUSH: begin
        sweeping = 1'b1;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(TABLE_ENTRIES - 1)) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        upd_ready  = (fifo_count < CNT_W'(DEPTH));
        head_valid = !fifo_empty;
        fifo_push  = bus.upd_valid && !fifo_full;
        fifo_pop   = head_valid;
        if (head_valid && is_mispredict(head)) cnt_d = sat_inc(cnt_q);
        if (bus.flush_req) begin
          state_d    = FLUSH;
          idx_d      = '0;
          fifo_clear = 1'b1;
        end
      end
      default: begin
        state_d = INIT;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.upd_ready          = upd_ready;
  assign bus.flush_busy         = sweeping;
  assign bus.pred_clear         = sweeping;
  assign bus.pred_clear_idx     = idx_q;
  assign bus.pred_update        = head_valid;
  assign bus.pred_pc            = head_valid ? head.pc        : '0;
  assign bus.pred_addr          = head_valid ? head.target    : '0;
  assign bus.pred_branch_result = head_valid ? head.taken     : 1'b0;
  assign bus.pred_prediction    = head_valid ? head.predicted : 1'b0;
  assign bus.pred_direction     = head_valid ? head.direction : 1'b0;
  assign bus.mispredict_cnt     = cnt_q;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Self-checking bench for bp_update_ctrl: directed table, hand-written corner
// sequences and random traffic checked against a queue-based reference model.
module tb_bp_update_ctrl;
  import branch_predictor_pkg::*;

  localparam int DEPTH = 4;
  localparam int TE    = 8;
  localparam int IDX_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_update_ctrl_if #(.IDX_W(IDX_W)) bus();

  bp_update_ctrl #(.DEPTH(DEPTH), .TABLE_ENTRIES(TE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: sweep position (TE means running), a queue of pending
  // updates and an unbounded counter clamped to 32 bits.
  int              sweep_pos;
  bp_update_t      mq[$];
  longint unsigned m_cnt;
  bp_update_t      cur_u;
  logic            cur_v;
  logic            cur_f;

  typedef struct {
    logic  valid;
    word_t pc;
    word_t target;
    logic  taken;
    logic  predicted;
    logic  exp_ready;
    logic  exp_update;
    word_t exp_pc;
    word_t exp_addr;
    word_t exp_cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    sweep_pos = 0;
    mq.delete();
    m_cnt = 0;
  endtask

  function automatic bp_update_t mk(input word_t pc, input word_t tgt, input logic t,
                                    input logic p, input logic d);
    bp_update_t u;
    u.pc = pc; u.target = tgt; u.taken = t; u.predicted = p; u.direction = d;
    return u;
  endfunction

  task automatic checkModel();
    bit         running;
    bit         has;
    bp_update_t h;
    running = (sweep_pos >= TE);
    has     = running && (mq.size() > 0);
    h       = '0;
    if (has) h = mq[0];
    checkOutput("ctrl ready/busy/clear/update",
                {bus.upd_ready, bus.flush_busy, bus.pred_clear, bus.pred_update},
                {running && (mq.size() < DEPTH), !running, !running, has});
    checkOutput("clear_idx", bus.pred_clear_idx, running ? 0 : sweep_pos);
    checkOutput("pred_pc", bus.pred_pc, h.pc);
    checkOutput("pred_addr", bus.pred_addr, h.target);
    checkOutput("pred_flags", {bus.pred_branch_result, bus.pred_prediction, bus.pred_direction},
                {h.taken, h.predicted, h.direction});
    checkOutput("mispredict_cnt", bus.mispredict_cnt, m_cnt);
  endtask

  // Called at a falling edge: drive inputs, let them settle, compare with the model.
  task automatic applyStimulus(input logic v, input bp_update_t u, input logic f);
    bus.upd_valid     = v;
    bus.upd_pc        = u.pc;
    bus.upd_target    = u.target;
    bus.upd_taken     = u.taken;
    bus.upd_predicted = u.predicted;
    bus.upd_direction = u.direction;
    bus.flush_req     = f;
    cur_v = v; cur_u = u; cur_f = f;
    #1;
    checkModel();
  endtask

  task automatic advanceModel();
    bit         accept;
    bp_update_t h;
    @(posedge clk);
    if (sweep_pos < TE) begin
      sweep_pos++;
    end else begin
      accept = cur_v && (mq.size() < DEPTH);
      if (mq.size() > 0) begin
        h = mq.pop_front();
        if (h.taken != h.predicted && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
      if (accept) mq.push_back(cur_u);
      if (cur_f) begin
        mq.delete();
        sweep_pos = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic stepCycle(input logic v, input bp_update_t u, input logic f);
    applyStimulus(v, u, f);
    advanceModel();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h100, 32'h80,   1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,    32'd0};
    vecs[1]  = '{1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h80,   32'd0};
    vecs[2]  = '{1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,    32'd1};
    vecs[3]  = '{1'b1, 32'h200, 32'h1000, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0,    32'd1};
    vecs[4]  = '{1'b1, 32'h204, 32'h2000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'h1000, 32'd1};
    vecs[5]  = '{1'b1, 32'h208, 32'h3000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h204, 32'h2000, 32'd1};
    vecs[6]  = '{1'b1, 32'h20C, 32'h4000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h208, 32'h3000, 32'd2};
    vecs[7]  = '{1'b1, 32'h210, 32'h5000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h20C, 32'h4000, 32'd2};
    vecs[8]  = '{1'b1, 32'h214, 32'h6000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h210, 32'h5000, 32'd2};
    vecs[9]  = '{1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 32'h214, 32'h6000, 32'd2};
    vecs[10] = '{1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,    32'd3};

    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_target = '0; bus.upd_taken = 1'b0;
    bus.upd_predicted = 1'b0; bus.upd_direction = 1'b0; bus.flush_req = 1'b0;
    cur_u = '0; cur_v = 1'b0; cur_f = 1'b0;
    modelReset();

    // Reset values with no clock edge required.
    #2;
    checkModel();
    checkOutput("reset upd_ready", bus.upd_ready, 0);
    checkOutput("reset flush_busy", bus.flush_busy, 1);

    @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset sweep");
    for (int i = 0; i < TE; i++) begin
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("sweep idx", bus.pred_clear_idx, i);
      checkOutput("sweep ready low", bus.upd_ready, 0);
      advanceModel();
    end

    $display("[TB] directed table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].valid, mk(vecs[i].pc, vecs[i].target, vecs[i].taken,
                    vecs[i].predicted, 1'b0), 1'b0);
      checkOutput($sformatf("vec%0d ready", i), bus.upd_ready, vecs[i].exp_ready);
      checkOutput($sformatf("vec%0d update", i), bus.pred_update, vecs[i].exp_update);
      checkOutput($sformatf("vec%0d pc", i), bus.pred_pc, vecs[i].exp_pc);
      checkOutput($sformatf("vec%0d addr", i), bus.pred_addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d cnt", i), bus.mispredict_cnt, vecs[i].exp_cnt);
      advanceModel();
    end

    $display("[TB] flush with queued entry");
    stepCycle(1'b1, mk(32'h300, 32'h3300, 1'b1, 1'b0, 1'b1), 1'b0);
    applyStimulus(1'b1, mk(32'h304, 32'h3304, 1'b0, 1'b1, 1'b0), 1'b1);
    checkOutput("flush head update", bus.pred_update, 1);
    checkOutput("flush head pc", bus.pred_pc, 32'h300);
    advanceModel();
    for (int i = 0; i < TE; i++) begin
      applyStimulus(1'b1, mk(32'h400, 32'h0, 1'b1, 1'b0, 1'b0), (i == 3));
      checkOutput("flush sweep idx", bus.pred_clear_idx, i);
      checkOutput("flush sweep busy", bus.flush_busy, 1);
      advanceModel();
    end
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("post-flush dropped entry", bus.pred_update, 0);
    checkOutput("post-flush cnt", bus.mispredict_cnt, 32'd4);
    advanceModel();

    $display("[TB] counter saturation");
    dut.cnt_q = 32'hFFFF_FFFE;
    m_cnt = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) stepCycle(1'b1, mk(32'h500 + i * 4, 32'h0, 1'b0, 1'b1, 1'b0), 1'b0);
    stepCycle(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("saturated cnt", bus.mispredict_cnt, 32'hFFFF_FFFF);
    advanceModel();

    $display("[TB] random traffic");
    dut.cnt_q = 32'd0;
    m_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      stepCycle($urandom_range(0, 3) != 0,
                mk($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom)),
                $urandom_range(0, 24) == 0);
    end

    $display("[TB] mid-operation reset");
    for (int i = 0; i < TE + 1 && sweep_pos < TE; i++) stepCycle(1'b0, '0, 1'b0);
    checkOutput("running before reset", sweep_pos >= TE, 1);
    stepCycle(1'b1, mk(32'h600, 32'h6600, 1'b1, 1'b0, 1'b0), 1'b0);
    applyStimulus(1'b1, mk(32'h604, 32'h6604, 1'b1, 1'b0, 1'b0), 1'b0);
    checkOutput("pre-reset update", bus.pred_update, 1);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkModel();
    checkOutput("async reset update", bus.pred_update, 0);
    checkOutput("async reset pc", bus.pred_pc, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < TE; i++) begin
      applyStimulus(1'b1, mk(32'h700, 32'h0, 1'b0, 1'b0, 1'b0), 1'b0);
      checkOutput("restart sweep idx", bus.pred_clear_idx, i);
      advanceModel();
    end
    for (int i = 0; i < 4; i++) stepCycle(1'b1, mk(32'h800 + i * 4, 32'h0, 1'b1, 1'b0, 1'b0), 1'b0);
    stepCycle(1'b0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
